txfifo_drain: RTL and testbench

Read-side controller for the MAC transmit FIFO. Pulls length-prefixed frames out of the 64-bit TX FIFO and presents them to the MAC TX datapath as a ready/valid word stream with start/end-of-frame markers and a last-word byte count. Sits between the FIFO read port (`rdclk` domain) and the TX framer, in the same clock domain as both.

---
 rtl/txfifo_drain_pkg.sv | 28 ++
 rtl/txfifo_drain_skid.sv | 75 +++++++
 rtl/txfifo_drain.sv | 196 +++++++++++++++++++
 tb/tb_txfifo_drain.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/txfifo_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : txfifo_drain_pkg
//  Description : Shared types and constants for the MAC TX FIFO drain block.
//  Revision    : 1.0 - initial release
// ============================================================================
package txfifo_drain_pkg;

    // Read-side controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Location of the byte-length field inside the header word
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_MSB = 15;

    // Bytes carried by one 64-bit FIFO word
    localparam int BYTES_PER_WORD = 8;

    // Largest legal frame (jumbo) in bytes
    localparam int MAX_BYTES_DEFAULT = 9600;

endpackage : txfifo_drain_pkg
`default_nettype wire

// File: rtl/txfifo_drain_skid.sv
`default_nettype none
// ============================================================================
//  Module      : txfifo_drain_skid
//  Description : Two-entry output buffer. The head entry drives the outputs
//                directly so they stay registered and hold steady while the
//                consumer stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module txfifo_drain_skid #(
    parameter int PAYLOAD_W = 69
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 i_push,
    input  logic [PAYLOAD_W-1:0] i_din,
    input  logic                 i_pop,
    output logic [PAYLOAD_W-1:0] o_dout,
    output logic                 o_valid,
    output logic [1:0]           o_count
);

    logic [PAYLOAD_W-1:0] r_head;
    logic [PAYLOAD_W-1:0] r_tail;
    logic [1:0]           r_cnt;

    logic w_pop;
    logic w_push;

    // A pop needs an entry; a push into a full buffer is only taken if a pop
    // frees a slot in the same cycle (the credit logic upstream prevents it).
    assign w_pop  = i_pop && (r_cnt != 2'd0);
    assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

    // Head/tail storage and occupancy; head keeps its value when emptied
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= i_din;
                    end else begin
                        r_tail <= i_din;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end else begin
                        r_head <= i_din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_dout  = r_head;
    assign o_valid = (r_cnt != 2'd0);
    assign o_count = r_cnt;

endmodule : txfifo_drain_skid
`default_nettype wire

// File: rtl/txfifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : txfifo_drain
//  Description : Pulls length-prefixed frames from the 64-bit TX FIFO and
//                streams them to the MAC TX framer with sof/eof/mod markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module txfifo_drain
    import txfifo_drain_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int LEN_W     = 16,
    parameter int MAX_BYTES = MAX_BYTES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_,
    output logic             rdreq,
    input  logic [WIDTH-1:0] q,
    input  logic             rdempty,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_sof,
    output logic             tx_eof,
    output logic [2:0]       tx_mod,
    output logic             len_err,
    output logic [15:0]      frames_sent
);

    localparam int               c_BYTE_SH   = $clog2(BYTES_PER_WORD);
    localparam int               c_WL_W      = LEN_W - c_BYTE_SH + 1;
    localparam int               c_PAYLOAD_W = WIDTH + 5;
    localparam logic [LEN_W-1:0] c_MAX_LEN   = LEN_W'(MAX_BYTES);
    localparam logic [c_WL_W-1:0] c_WL_ONE   = c_WL_W'(1);

    // Controller state
    state_t              r_state;
    logic [c_WL_W-1:0]   r_words_left;
    logic [2:0]          r_mod;
    logic                r_first;
    logic                r_len_err;
    logic                r_run;

    // Tags travelling alongside a data read until its word returns
    logic                r_inflight;
    logic                r_rd_sof;
    logic                r_rd_eof;
    logic [2:0]          r_rd_mod;

    logic [15:0]         r_frames;

    logic [LEN_W-1:0]    w_len;
    logic [c_WL_W-1:0]   w_words;
    logic                w_len_bad;
    logic [1:0]          w_buf_cnt;
    logic                w_pop;
    logic [2:0]          w_occ;
    logic                w_credit;
    logic                w_rdreq;
    logic                w_data_rd;
    logic [c_PAYLOAD_W-1:0] w_push_data;
    logic [c_PAYLOAD_W-1:0] w_dout;
    logic                w_valid;

    // Header decode: reserved bits above the length field are ignored
    assign w_len     = q[HDR_LEN_MSB:HDR_LEN_LSB];
    assign w_len_bad = (w_len == '0) || (w_len > c_MAX_LEN);
    // ceil(len / 8) without an add carry on the full length
    assign w_words   = {1'b0, w_len[LEN_W-1:c_BYTE_SH]}
                     + c_WL_W'(|w_len[c_BYTE_SH-1:0]);

    assign w_pop = w_valid && tx_ready;

    // Occupancy the buffer will reach once the read in flight lands; a new
    // data read is only allowed if that leaves room for its word too.
    assign w_occ    = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit = (w_occ < 3'd2);

    // Read request: combinational so rdempty is honoured in the same cycle.
    // Header reads never land in the buffer, so they bypass the credit check.
    always_comb begin
        w_rdreq = 1'b0;
        case (r_state)
            IDLE:    w_rdreq = r_run && !rdempty;
            DATA:    w_rdreq = r_run && !rdempty && (r_words_left != '0) && w_credit;
            default: w_rdreq = 1'b0;
        endcase
    end

    assign w_data_rd = w_rdreq && (r_state == DATA);
    assign rdreq     = w_rdreq;

    // Holds reads off while reset is asserted and for the first clock after
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Frame sequencing: header fetch, decode, data reads, error lock-up
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state      <= IDLE;
            r_words_left <= '0;
            r_mod        <= 3'd0;
            r_first      <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rdreq) begin
                        r_state <= HDR;
                    end
                end
                HDR: begin
                    if (w_len_bad) begin
                        r_len_err <= 1'b1;
                        r_state   <= ERR;
                    end else begin
                        r_words_left <= w_words;
                        r_mod        <= w_len[2:0];
                        r_first      <= 1'b1;
                        r_state      <= DATA;
                    end
                end
                DATA: begin
                    if (w_data_rd) begin
                        r_words_left <= r_words_left - c_WL_ONE;
                        r_first      <= 1'b0;
                        if (r_words_left == c_WL_ONE) begin
                            r_state <= IDLE;
                        end
                    end
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Remember what the outstanding data read is, to tag it on arrival
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_inflight <= 1'b0;
            r_rd_sof   <= 1'b0;
            r_rd_eof   <= 1'b0;
            r_rd_mod   <= 3'd0;
        end else begin
            r_inflight <= w_data_rd;
            r_rd_sof   <= r_first;
            r_rd_eof   <= (r_words_left == c_WL_ONE);
            r_rd_mod   <= r_mod;
        end
    end

    // mod only carries meaning on the eof word; keep it zero elsewhere
    assign w_push_data = {q, r_rd_sof, r_rd_eof, (r_rd_eof ? r_rd_mod : 3'd0)};

    txfifo_drain_skid #(
        .PAYLOAD_W (c_PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .reset_  (reset_),
        .i_push  (r_inflight),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_valid (w_valid),
        .o_count (w_buf_cnt)
    );

    // Completed-frame counter, wraps naturally at 2^16
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_frames <= 16'd0;
        end else if (w_pop && tx_eof) begin
            r_frames <= r_frames + 16'd1;
        end
    end

    assign tx_data     = w_dout[c_PAYLOAD_W-1:5];
    assign tx_sof      = w_dout[4];
    assign tx_eof      = w_dout[3];
    assign tx_mod      = w_dout[2:0];
    assign tx_valid    = w_valid;
    assign len_err     = r_len_err;
    assign frames_sent = r_frames;

endmodule : txfifo_drain
`default_nettype wire

// File: tb/tb_txfifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_txfifo_drain
//  Description : Self-checking bench for txfifo_drain with a FIFO model and
//                a beat scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_txfifo_drain;

    typedef struct packed {
        logic [63:0] data;
        logic        sof;
        logic        eof;
        logic [2:0]  mod;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        rdreq;
    logic [63:0] q = 64'd0;
    logic        rdempty;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_sof;
    logic        tx_eof;
    logic [2:0]  tx_mod;
    logic        len_err;
    logic [15:0] frames_sent;

    logic [63:0] fifo[$];
    logic [63:0] pend[$];
    beat_t       sb[$];
    int          pushed_cnt = 0;
    int          popped_cnt = 0;
    int          checks = 0;
    int          fails = 0;
    int          exp_frames = 0;
    bit          rd_fire = 1'b0;
    bit          prev_stall = 1'b0;
    beat_t       prev_beat;
    beat_t       mon_cur;
    beat_t       mon_exp;

    txfifo_drain dut (
        .clk         (clk),
        .reset_      (reset_),
        .rdreq       (rdreq),
        .q           (q),
        .rdempty     (rdempty),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_sof      (tx_sof),
        .tx_eof      (tx_eof),
        .tx_mod      (tx_mod),
        .len_err     (len_err),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    assign rdempty = (pushed_cnt == popped_cnt);

    // Show-ahead-free FIFO model: data appears on q the cycle after rdreq
    always @(posedge clk) begin
        if (rd_fire) begin
            q          <= fifo.pop_front();
            popped_cnt <= popped_cnt + 1;
        end
    end

    // Output monitor: scoreboard compare, hold-while-stalled, no underflow
    always @(negedge clk) begin
        if (reset_) begin
            mon_cur = '{data: tx_data, sof: tx_sof, eof: tx_eof,
                        mod: (tx_eof ? tx_mod : 3'd0)};
            if (prev_stall) begin
                checks++;
                if (!tx_valid || (mon_cur !== prev_beat)) begin
                    fails++;
                    $display("FAIL hold_while_stalled: got valid=%0b beat=%h, want valid=1 beat=%h",
                             tx_valid, mon_cur, prev_beat);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got beat=%h, want no beat", mon_cur);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_cur !== mon_exp) begin
                        fails++;
                        $display("FAIL beat: got data=%h sof=%0b eof=%0b mod=%0d, want data=%h sof=%0b eof=%0b mod=%0d",
                                 mon_cur.data, mon_cur.sof, mon_cur.eof, mon_cur.mod,
                                 mon_exp.data, mon_exp.sof, mon_exp.eof, mon_exp.mod);
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_beat  = mon_cur;
            if (rdreq) begin
                checks++;
                if (rdempty) begin
                    fails++;
                    $display("FAIL fifo_underflow: got rdreq=1 with rdempty=1, want rdreq=0");
                end
            end
            rd_fire = rdreq && !rdempty;
        end else begin
            prev_stall = 1'b0;
            rd_fire    = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_push(input logic [63:0] w);
        fifo.push_back(w);
        pushed_cnt++;
    endtask

    // Load header plus the first first_n data words; the rest wait in pend
    task automatic load_frame(input int len, input int first_n);
        int          nw;
        logic [63:0] w;
        logic [15:0] l16;
        nw  = (len + 7) / 8;
        l16 = len[15:0];
        fifo_push({$urandom, 16'($urandom), l16});
        pend.delete();
        for (int i = 0; i < nw; i++) begin
            w = {$urandom, $urandom};
            sb.push_back('{data: w, sof: (i == 0), eof: (i == nw - 1),
                           mod: ((i == nw - 1) ? 3'(len % 8) : 3'd0)});
            if (i < first_n) fifo_push(w);
            else pend.push_back(w);
        end
        exp_frames++;
    endtask

    task automatic wait_drain(input int budget, input bit toggle, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            if (toggle) tx_ready = ~tx_ready;
            step();
        end
        tx_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        fifo.delete();
        pend.delete();
        sb.delete();
        pushed_cnt = popped_cnt;
        exp_frames = 0;
        repeat (3) step();
        reset_ = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rdreq, tx_valid, tx_sof, tx_eof, len_err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got rdreq/valid/sof/eof/len_err=%b, want 00000",
                     {rdreq, tx_valid, tx_sof, tx_eof, len_err});
        end
        checks++;
        if (tx_data !== 64'd0 || tx_mod !== 3'd0) begin
            fails++;
            $display("FAIL reset_data: got data=%h mod=%0d, want data=0 mod=0", tx_data, tx_mod);
        end
        checks++;
        if (frames_sent !== 16'd0) begin
            fails++;
            $display("FAIL reset_frames: got %0d, want 0", frames_sent);
        end
    endtask

    task automatic test_single_64();
        int cyc  = 0;
        int t_rd = -1;
        int t_v  = -1;
        bit ok   = 1'b0;
        load_frame(64, 99);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rdreq && t_rd < 0) t_rd = cyc;
            if (tx_valid && t_v < 0) t_v = cyc;
            cyc++;
            if (sb.size() == 0) ok = 1'b1;
        end
        step();
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL single_drain: got %0d beats outstanding, want 0", sb.size());
        end
        checks++;
        if (t_v - t_rd != 4) begin
            fails++;
            $display("FAIL first_latency: got %0d cycles, want 4", t_v - t_rd);
        end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin
            fails++;
            $display("FAIL single_frames: got %0d, want %0d", frames_sent, exp_frames);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        load_frame(61, 99);
        load_frame(8, 99);
        wait_drain(200, 1'b0, ok);
        step();
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_drain: got %0d beats outstanding, want 0", sb.size());
        end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin
            fails++;
            $display("FAIL b2b_frames: got %0d, want %0d", frames_sent, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        load_frame(200, 99);
        wait_drain(400, 1'b1, ok);
        step();
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_drain: got %0d beats outstanding, want 0", sb.size());
        end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin
            fails++;
            $display("FAIL bp_frames: got %0d, want %0d", frames_sent, exp_frames);
        end
    endtask

    task automatic test_empty_stall();
        bit ok = 1'b0;
        load_frame(64, 3);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 5) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_first3: got %0d beats outstanding, want 5", sb.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_valid !== 1'b0 || rdreq !== 1'b0) begin
                fails++;
                $display("FAIL stall_idle: got valid=%0b rdreq=%0b, want 0 0", tx_valid, rdreq);
            end
            step();
        end
        while (pend.size() > 0) fifo_push(pend.pop_front());
        wait_drain(200, 1'b0, ok);
        step();
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_resume: got %0d beats outstanding, want 0", sb.size());
        end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin
            fails++;
            $display("FAIL stall_frames: got %0d, want %0d", frames_sent, exp_frames);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok = 1'b0;
        load_frame(64, 99);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 5) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL mid_reach_word4: got %0d beats outstanding, want 5", sb.size());
        end
        reset_ = 1'b0;
        #1;
        checks++;
        if ({rdreq, tx_valid, tx_sof, tx_eof} !== 4'b0 || tx_data !== 64'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got rdreq/valid/sof/eof=%b data=%h, want 0000 0",
                     {rdreq, tx_valid, tx_sof, tx_eof}, tx_data);
        end
        checks++;
        if (frames_sent !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset_frames: got %0d, want 0", frames_sent);
        end
        do_reset();
        load_frame(16, 99);
        wait_drain(100, 1'b0, ok);
        step();
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL mid_fresh_drain: got %0d beats outstanding, want 0", sb.size());
        end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin
            fails++;
            $display("FAIL mid_fresh_frames: got %0d, want %0d", frames_sent, exp_frames);
        end
    endtask

    task automatic test_len_err(input int len);
        int          n_rd = 0;
        int          n_v  = 0;
        logic [15:0] l16;
        l16 = len[15:0];
        fifo_push({$urandom, 16'($urandom), l16});
        fifo_push({$urandom, $urandom});
        fifo_push({$urandom, $urandom});
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rdreq) n_rd++;
            if (tx_valid) n_v++;
        end
        step();
        checks++;
        if (len_err !== 1'b1) begin
            fails++;
            $display("FAIL len_err_set(len=%0d): got %0b, want 1", len, len_err);
        end
        checks++;
        if (n_v != 0) begin
            fails++;
            $display("FAIL len_err_no_valid(len=%0d): got %0d valid cycles, want 0", len, n_v);
        end
        checks++;
        if (n_rd != 1) begin
            fails++;
            $display("FAIL len_err_rdreq(len=%0d): got %0d read cycles, want 1", len, n_rd);
        end
        do_reset();
        checks++;
        if (len_err !== 1'b0) begin
            fails++;
            $display("FAIL len_err_clear(len=%0d): got %0b, want 0", len, len_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_64();
        test_back_to_back();
        test_backpressure();
        test_empty_stall();
        test_reset_midframe();
        test_len_err(0);
        test_len_err(9601);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_txfifo_drain
`default_nettype wire
